// File: rtl/hex_display_ctrl.sv
// Registered multi-digit hex to seven-segment driver with leading-zero blanking,
// per-digit blink and lamp test.
module hex_display_ctrl #(
  parameter int unsigned NDIG       = 6,
  parameter int unsigned BLINK_DIV  = 25000000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*NDIG-1:0]   value,
  input  logic                blank_lz,
  input  logic [NDIG-1:0]     blink_en,
  input  logic                lamp_test,
  output logic [7*NDIG-1:0]   seg,
  output logic                load_ack
);

  localparam int unsigned VAL_W = 4 * NDIG;
  localparam int unsigned SEG_W = 7 * NDIG;
  localparam int unsigned PRE_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BLINK_DIV - 1);
  localparam logic [SEG_W-1:0] SEG_OFF  = {SEG_W{ACTIVE_LOW}};

  logic [VAL_W-1:0] val_r;
  logic [PRE_W-1:0] pre;
  logic             phase;
  logic             load_d;
  logic             lamp_r;
  logic             blz_r;
  logic [NDIG-1:0]  ben_r;
  logic [SEG_W-1:0] seg_nxt_c;

  // Active-high a..g glyphs for one hex digit
  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h67;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      4'hF: g = 7'h71;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  // Level inputs get one stage so they line up with val_r on seg
  always_ff @(posedge clk) begin
    lamp_r <= lamp_test;
    blz_r  <= blank_lz;
    ben_r  <= blink_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      val_r    <= '0;
      pre      <= '0;
      phase    <= 1'b1;
      load_d   <= 1'b0;
      load_ack <= 1'b0;
      seg      <= SEG_OFF;
    end else begin
      if (load) val_r <= value;
      if (pre == PRE_LAST) begin
        pre   <= '0;
        phase <= ~phase;
      end else begin
        pre <= pre + PRE_W'(1);
      end
      load_d   <= load;
      load_ack <= load_d;
      seg      <= seg_nxt_c;
    end
  end

  logic       lead;
  logic       blank;
  logic [3:0] digit;
  logic [6:0] on;

  // Scan from the top digit: zeros stay blank until the first nonzero digit
  always_comb begin
    seg_nxt_c = '0;
    lead      = 1'b1;
    blank     = 1'b0;
    digit     = '0;
    on        = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      digit = val_r[4*i +: 4];
      blank = blz_r && lead && (digit == 4'h0) && (i != 0);
      if (digit != 4'h0) lead = 1'b0;
      if (!phase && ben_r[i]) blank = 1'b1;
      if (lamp_r)     on = 7'h7F;
      else if (blank) on = 7'h00;
      else            on = hex7(digit);
      seg_nxt_c[7*i +: 7] = ACTIVE_LOW ? ~on : on;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomised scoreboard bench for hex_display_ctrl against a cycle-level reference model.
module tb_hex_display_ctrl;

  localparam int unsigned NDIG = 6;
  localparam int unsigned BDIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [23:0] value;
  logic        blank_lz;
  logic [5:0]  blink_en;
  logic        lamp_test;
  logic [41:0] seg;
  logic        load_ack;

  always #5 clk = ~clk;

  hex_display_ctrl #(.NDIG(NDIG), .BLINK_DIV(BDIV), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .blank_lz(blank_lz),
    .blink_en(blink_en), .lamp_test(lamp_test), .seg(seg), .load_ack(load_ack)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] glyph [16];

  typedef struct {
    logic [41:0] seg;
    logic        ack;
  } exp_t;

  exp_t        expq[$];
  logic [23:0] loadq[$];

  // Display image from the digit rules, active-low
  function automatic logic [41:0] render(logic [23:0] v, logic lamp, logic blz,
                                         logic [5:0] ben, logic ph);
    logic [41:0] r;
    logic [6:0]  g;
    logic [3:0]  d;
    logic        lz;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      d  = 4'((v >> (4 * i)) & 24'hF);
      lz = blz && (i > 0) && ((v >> (4 * i)) == 24'h0);
      if (lamp)                   g = 7'h7F;
      else if (lz || (!ph && ben[i])) g = 7'h00;
      else                        g = glyph[d];
      r[7*i +: 7] = ~g;
    end
    return r;
  endfunction

  // Reference model: state as of the previous edge
  logic [23:0] m_val  = '0;
  logic        m_lamp = 1'b0;
  logic        m_blz  = 1'b0;
  logic [5:0]  m_ben  = '0;
  int unsigned m_cnt  = 0;
  logic        m_load = 1'b0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    if (reset) begin
      e.seg = '1;
      e.ack = 1'b0;
    end else begin
      e.seg = render(m_val, m_lamp, m_blz, m_ben, ((m_cnt / BDIV) % 2) == 0);
      e.ack = m_load;
    end
    if (reset || m_valid) expq.push_back(e);
    if (reset) m_valid = 1'b1;
    m_val  = reset ? 24'h0 : (load ? value : m_val);
    m_cnt  = reset ? 0 : m_cnt + 1;
    m_lamp = lamp_test;
    m_blz  = blank_lz;
    m_ben  = blink_en;
    m_load = !reset && load;
  end

  // Monitor: compares every presented output after the edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      n_checks++;
      if (seg !== e.seg) begin
        n_fail++;
        $display("FAIL seg t=%0t got=%h exp=%h", $time, seg, e.seg);
      end
      n_checks++;
      if (load_ack !== e.ack) begin
        n_fail++;
        $display("FAIL load_ack t=%0t got=%b exp=%b", $time, load_ack, e.ack);
      end
    end
    if (load_ack === 1'b1) begin
      n_checks++;
      if (loadq.size() == 0) begin
        n_fail++;
        $display("FAIL ack_pending t=%0t got=ack exp=no_pending_load", $time);
      end else begin
        void'(loadq.pop_front());
      end
    end
  end

  task automatic cyc(input bit rst, input bit ld, input logic [23:0] v);
    @(negedge clk);
    reset = rst;
    load  = ld;
    value = v;
    if (rst)     loadq.delete();
    else if (ld) loadq.push_back(v);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] rv;
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    reset = 1'b1; load = 1'b0; value = '0;
    blank_lz = 1'b0; blink_en = '0; lamp_test = 1'b0;

    cyc(1, 0, 0); cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 24'h0123AF);
    repeat (3) cyc(0, 0, 0);

    for (int i = 0; i < 16; i++) cyc(0, 1, 24'(i));
    repeat (2) cyc(0, 0, 0);

    blank_lz = 1'b1;
    cyc(0, 1, 24'h000305); repeat (2) cyc(0, 0, 0);
    cyc(0, 1, 24'h000000); repeat (2) cyc(0, 0, 0);
    blank_lz = 1'b0;
    repeat (2) cyc(0, 0, 0);

    cyc(1, 0, 0);
    blink_en = 6'b000011;
    cyc(0, 1, 24'h123456);
    repeat (20) cyc(0, 0, 0);

    blank_lz = 1'b1;
    cyc(0, 1, 24'h000012);
    repeat (3) cyc(0, 0, 0);
    lamp_test = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 1, 24'hABCDEF);
    repeat (2) cyc(0, 0, 0);
    lamp_test = 1'b0;
    repeat (3) cyc(0, 0, 0);

    cyc(0, 0, 0);
    cyc(1, 1, 24'h777777);
    repeat (12) cyc(0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) blink_en = 6'($urandom);
      lamp_test = ($urandom_range(0, 9) == 0);
      rv = 24'($urandom >> $urandom_range(0, 24));
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0, rv);
    end

    lamp_test = 1'b0;
    repeat (4) cyc(0, 0, 0);
    n_checks++;
    if (loadq.size() != 0) begin
      n_fail++;
      $display("FAIL unacked_loads got=%0d exp=0", loadq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
